// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises raw switch lines and accepts a level only after it holds for STABLE_CYCLES
module switch_debouncer #(
    parameter int WIDTH         = 8,
    parameter int CNT_WIDTH     = 16,
    parameter int STABLE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [WIDTH-1:0] clear_change,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] change_flag
);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]     sync1, sync2, accept;
    logic [CNT_WIDTH-1:0] cnt [WIDTH];

    // a bit is accepted when it differs from the filtered level for the final counted cycle
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++)
            accept[i] = (sync2[i] != debounced_out[i]) && (cnt[i] == LAST);
    end

    // synchroniser, per-bit stability counters, filtered level, pulses and sticky flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1         <= '0;
            sync2         <= '0;
            debounced_out <= '0;
            rise_pulse    <= '0;
            fall_pulse    <= '0;
            change_flag   <= '0;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            sync1         <= raw_in;
            sync2         <= sync1;
            debounced_out <= debounced_out ^ accept;
            rise_pulse    <= accept & sync2;
            fall_pulse    <= accept & ~sync2;
            change_flag   <= accept | (change_flag & ~clear_change);
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= (sync2[i] == debounced_out[i] || accept[i]) ? '0 : cnt[i] + 1'b1;
        end
    end
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed and random stimulus checked against a sliding-window reference model
module tb_switch_debouncer;
    localparam int S = 4;

    logic       clk = 0;
    logic       reset_n = 0;
    logic [7:0] raw_in = 0, clear_change = 0;
    logic [7:0] debounced_out, rise_pulse, fall_pulse, change_flag;

    int total = 0, bad = 0;

    logic [7:0] m_p1, m_p2, m_deb, m_rise, m_fall, m_flag;
    logic [7:0] win [S];

    switch_debouncer #(.WIDTH(8), .CNT_WIDTH(16), .STABLE_CYCLES(S)) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .clear_change(clear_change),
        .debounced_out(debounced_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .change_flag(change_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // filter input at each edge is the raw value two edges earlier; a bit flips once the
    // last S filter inputs all disagree with its current level
    task automatic model_edge();
        logic [7:0] seen, m;
        if (!reset_n) begin
            {m_p1, m_p2, m_deb, m_rise, m_fall, m_flag} = '0;
            for (int i = 0; i < S; i++) win[i] = '0;
        end else begin
            seen = m_p2;
            m_p2 = m_p1;
            m_p1 = raw_in;
            for (int i = S - 1; i > 0; i--) win[i] = win[i-1];
            win[0] = seen;
            m = 8'hFF;
            for (int i = 0; i < S; i++) m &= win[i] ^ m_deb;
            m_rise = m & ~m_deb;
            m_fall = m & m_deb;
            m_flag = m | (m_flag & ~clear_change);
            m_deb  = m_deb ^ m;
        end
    endtask

    task automatic cyc(input logic [7:0] r, input logic [7:0] c, input logic rn, input int n);
        raw_in = r;
        clear_change = c;
        reset_n = rn;
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("debounced_out", debounced_out, m_deb);
            chk("rise_pulse", rise_pulse, m_rise);
            chk("fall_pulse", fall_pulse, m_fall);
            chk("change_flag", change_flag, m_flag);
        end
    endtask

    initial begin
        logic [7:0] r, c;
        logic rn;
        // reset with switches high, then low, then released
        cyc(8'hFF, 8'h00, 0, 3);
        chk("reset_ff_deb", debounced_out, 8'h00);
        cyc(8'h00, 8'h00, 0, 3);
        cyc(8'h00, 8'h00, 1, 20);
        chk("idle_flag", change_flag, 8'h00);
        // clean rise on bit 0
        cyc(8'h01, 8'h00, 1, 5);
        chk("rise_early", debounced_out, 8'h00);
        cyc(8'h01, 8'h00, 1, 1);
        chk("rise_deb", debounced_out, 8'h01);
        chk("rise_pulse_hi", rise_pulse, 8'h01);
        cyc(8'h01, 8'h00, 1, 1);
        chk("rise_pulse_lo", rise_pulse, 8'h00);
        chk("rise_flag", change_flag, 8'h01);
        // bounce on bit 1 never accepted
        cyc(8'h03, 8'h00, 1, 3);
        cyc(8'h01, 8'h00, 1, 2);
        cyc(8'h03, 8'h00, 1, 3);
        cyc(8'h01, 8'h00, 1, 10);
        chk("bounce_deb", debounced_out, 8'h01);
        // simultaneous rise of bit 7 and fall of bit 0
        cyc(8'h80, 8'h00, 1, 6);
        chk("mixed_rise", rise_pulse, 8'h80);
        chk("mixed_fall", fall_pulse, 8'h01);
        chk("mixed_flag", change_flag, 8'h81);
        cyc(8'h80, 8'h00, 1, 3);
        // clear with no transitions, then clear held through an acceptance
        cyc(8'h80, 8'h81, 1, 1);
        chk("clear_flag", change_flag, 8'h00);
        cyc(8'h81, 8'h01, 1, 6);
        chk("clear_vs_set", change_flag, 8'h01);
        cyc(8'h81, 8'h00, 1, 3);
        // reset during a count discards progress
        cyc(8'h00, 8'h00, 0, 2);
        cyc(8'h04, 8'h00, 1, 3);
        cyc(8'h04, 8'h00, 0, 1);
        cyc(8'h04, 8'h00, 1, 5);
        chk("rst_mid_wait", debounced_out, 8'h00);
        cyc(8'h04, 8'h00, 1, 1);
        chk("rst_mid_deb", debounced_out, 8'h04);
        chk("rst_mid_rise", rise_pulse, 8'h04);
        // random bouncing switches, sparse clears and occasional reset
        r = 8'h04;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
            rn = ($urandom_range(0, 400) != 0);
            cyc(r, c, rn, $urandom_range(1, 6));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions raw board slide-switch/push-button lines before they reach the PIO input peripheral's in_port.
- Synchronises each bit to clk and accepts a level change only after it has been stable for STABLE_CYCLES consecutive cycles.
- Flags every accepted change with single-cycle rise/fall pulses and a sticky per-bit change flag.
- debounced_out connects directly to the switches PIO in_port.

Parameters:
- WIDTH, 8: number of switch lines.
- CNT_WIDTH, 16: width of each per-bit stability counter.
- STABLE_CYCLES, 50000: consecutive cycles a new level must persist before it is accepted (1 ms at 50 MHz). Legal range 1 <= STABLE_CYCLES <= 2^CNT_WIDTH - 1.

Ports:
- clk, input, 1: system clock; sole clock domain.
- reset_n, input, 1: reset, synchronous, active-low.
- raw_in, input, WIDTH: asynchronous switch pins.
- clear_change, input, WIDTH: per-bit clear for change_flag; level-sensitive, sampled each edge.
- debounced_out, output, WIDTH: filtered switch levels; feeds the PIO in_port.
- rise_pulse, output, WIDTH: one-cycle pulse when a debounced bit goes 0->1.
- fall_pulse, output, WIDTH: one-cycle pulse when a debounced bit goes 1->0.
- change_flag, output, WIDTH: sticky, set on any debounced transition of that bit.

Behaviour:
- Reset:
  - Applies on a clk edge with reset_n=0.
  - Clears both synchroniser stages, all counters, debounced_out, rise_pulse, fall_pulse and change_flag to 0.
  - Reset mid-count discards all progress; no pulse is generated by reset.
- Synchroniser: two flops per bit (sync1 <= raw_in, sync2 <= sync1). Only sync2 is used downstream.
- Per-bit filter, evaluated every edge when reset_n=1:
  - sync2 == debounced bit: counter <= 0.
  - sync2 != debounced bit and counter < STABLE_CYCLES-1: counter <= counter+1.
  - sync2 != debounced bit and counter == STABLE_CYCLES-1: debounced bit <= sync2; counter <= 0.
- Any bounce back to the debounced level before acceptance restarts the count from 0.
- Latency: raw change first sampled at edge 1 gives debounced_out update at edge STABLE_CYCLES+2. With STABLE_CYCLES=1, update occurs at edge 3.
- Pulses:
  - rise_pulse[i] / fall_pulse[i] are registered and high for exactly the one cycle following the edge on which debounced_out[i] changes; 0 otherwise.
  - Rise and fall are never both high on the same bit.
- change_flag[i]:
  - Set on the same edge as the rise/fall pulse.
  - Cleared on an edge with clear_change[i]=1 and no transition.
  - Transition and clear on the same edge: set wins (flag stays 1).
- Bits are fully independent; simultaneous transitions on several bits each produce their own pulses on the same cycle.
- Power-up with switches high: debounced_out starts 0 and rises after STABLE_CYCLES+2 edges, producing rise pulses and setting change_flag. Software clears the flag after boot.
- Counters never wrap: maximum value reached is STABLE_CYCLES-1.

Test Plan (STABLE_CYCLES=4, WIDTH=8):
- Reset: raw_in=0x00, reset_n low 3 edges then high 20 edges -> all outputs 0x00 throughout. Also: raw_in=0xFF held during reset -> outputs 0x00 while reset_n=0.
- Clean rise: raw_in 0x00->0x01 sampled at edge 1 and held -> debounced_out=0x01 after edge 6; rise_pulse=0x01 for exactly one cycle after edge 6, then 0x00; change_flag=0x01 stays set.
- Bounce rejection: raw_in bit0 high for 3 cycles, low 2, high 3, then low -> debounced_out, rise_pulse, fall_pulse and change_flag remain 0x00.
- Mixed multi-bit: from debounced 0x01, raw_in -> 0x80 held -> after edge 6: debounced_out=0x80, rise_pulse=0x80 and fall_pulse=0x01 on the same single cycle; change_flag=0x81.
- Clear priority: change_flag=0x81 with clear_change=0x81 for one edge and no transitions -> change_flag=0x00. Then clear_change=0x01 asserted on the same edge that bit0 is accepted -> change_flag[0]=1.
- Reset mid-operation: raw_in 0x00->0x04, reset_n low at edge 4 for one edge, then high with raw_in still 0x04 -> debounced_out=0x00 until the full STABLE_CYCLES+2 edges after release, then 0x04 with one rise pulse.
